wb_fake_slave_pipe_nb: RTL and testbench

- Behavioural Wishbone B4 pipelined-mode slave, single beats only, no bursts; stands in for a real peripheral when exercising the NIC bus master.
- Backed by a small internal word memory; returns one registered response per accepted request.
- Inserts periodic stall cycles to exercise master back-pressure; asserts a grant flag while a master owns the bus.

---
 rtl/wb_fake_slave_pipe_nb_if.sv | 49 ++++
 rtl/wb_fake_slave_pipe_nb.sv | 138 +++++++++++++
 tb/tb_wb_fake_slave_pipe_nb.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_fake_slave_pipe_nb_if.sv
// -----------------------------------------------------------------------------
// wb_fake_slave_pipe_nb_if
// Wishbone B4 pipelined-mode bus bundle between a bus master and the fake
// slave. Signal names follow the slave's point of view (_I driven by the
// master, _O driven by the slave).
//
// Handshake: a request is transferred on a rising clk edge where CYC_I=1,
// STB_I=1 and STALL_O=0. While STALL_O=1 the master keeps the request stable.
// Each transferred request is answered by exactly one of ACK_O/ERR_O/RTY_O,
// high for one cycle, in the cycle after the transfer edge. Dropping CYC_I
// abandons any response that has not yet been seen.
//
// Signals:
//   CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, CTI_I   master -> slave
//   gnt_wb_o, DAT_O, ACK_O, RTY_O, ERR_O, STALL_O     slave  -> master
// Modports: master, slave.
// -----------------------------------------------------------------------------
interface wb_fake_slave_pipe_nb_if #(
   parameter int BUS_ADDRESS_WIDTH = 32,
   parameter int BUS_DATA_WIDTH    = 32,
   parameter int GRANULARITY       = 8
);
   localparam int SEL_WIDTH = BUS_DATA_WIDTH / GRANULARITY;

   logic                         CYC_I;
   logic                         STB_I;
   logic                         WE_I;
   logic [BUS_ADDRESS_WIDTH-1:0] ADR_I;
   logic [BUS_DATA_WIDTH-1:0]    DAT_I;
   logic [SEL_WIDTH-1:0]         SEL_I;
   logic [2:0]                   CTI_I;

   logic                         gnt_wb_o;
   logic [BUS_DATA_WIDTH-1:0]    DAT_O;
   logic                         ACK_O;
   logic                         RTY_O;
   logic                         ERR_O;
   logic                         STALL_O;

   modport master (
      output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, CTI_I,
      input  gnt_wb_o, DAT_O, ACK_O, RTY_O, ERR_O, STALL_O
   );

   modport slave (
      input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, CTI_I,
      output gnt_wb_o, DAT_O, ACK_O, RTY_O, ERR_O, STALL_O
   );
endinterface

// File: rtl/wb_fake_slave_pipe_nb.sv
// -----------------------------------------------------------------------------
// wb_fake_slave_pipe_nb
// Behavioural Wishbone B4 pipelined single-beat slave backed by a small word
// memory. Used in place of a real peripheral when exercising a bus master:
// it answers every accepted beat one cycle later, inserts a one-cycle stall
// after every STALL_EVERY accepted beats, and flags bus ownership on gnt_wb_o.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset (memory reloads mem[i] = i)
//   wb   slave modport of wb_fake_slave_pipe_nb_if
//
// Responses per accepted beat (priority order):
//   CTI_I not classic (000) or end-of-burst (111) -> RTY_O, no memory access
//   word index >= MEM_WORDS                        -> ERR_O, no memory access
//   otherwise                                      -> ACK_O (read or byte-lane write)
// -----------------------------------------------------------------------------
module wb_fake_slave_pipe_nb #(
   parameter int BUS_ADDRESS_WIDTH = 32,
   parameter int BUS_DATA_WIDTH    = 32,
   parameter int GRANULARITY       = 8,
   parameter int MEM_WORDS         = 16,
   parameter int STALL_EVERY       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   wb_fake_slave_pipe_nb_if.slave wb
);
   localparam int AW        = BUS_ADDRESS_WIDTH;
   localparam int DW        = BUS_DATA_WIDTH;
   localparam int G         = GRANULARITY;
   localparam int SEL_W     = DW / G;
   localparam int OFF_BITS  = $clog2(DW / 8);
   localparam int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   // Counter only ever holds 0..STALL_EVERY-1.
   localparam int CNT_W     = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
   localparam int LAST_BEAT = (STALL_EVERY > 0) ? STALL_EVERY - 1 : 0;
   localparam logic [AW-1:0] MEM_WORDS_A = AW'(MEM_WORDS);

   logic [DW-1:0]    mem [MEM_WORDS];

   logic [AW-1:0]    word_idx;
   logic [IDX_W-1:0] mem_idx;
   logic             in_range;
   logic             cti_ok;
   logic             accept;

   logic             ack_q;
   logic             err_q;
   logic             rty_q;
   logic             is_read_q;
   logic [DW-1:0]    rd_data_q;
   logic [DW-1:0]    dat_hold_q;
   logic [DW-1:0]    dat_out;
   logic             stall_q;
   logic             gnt_q;
   logic [CNT_W-1:0] beat_cnt;

   // Full-width index is kept so addresses beyond the memory are detected
   // rather than aliased; the byte-offset bits are simply shifted away.
   assign word_idx = wb.ADR_I >> OFF_BITS;
   assign in_range = (word_idx < MEM_WORDS_A);
   assign mem_idx  = word_idx[IDX_W-1:0];
   assign cti_ok   = (wb.CTI_I == 3'b000) || (wb.CTI_I == 3'b111);
   assign accept   = wb.CYC_I & wb.STB_I & ~stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rty_q      <= 1'b0;
         is_read_q  <= 1'b0;
         rd_data_q  <= '0;
         dat_hold_q <= '0;
         stall_q    <= 1'b0;
         gnt_q      <= 1'b0;
         beat_cnt   <= '0;
         for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] <= DW'(i);
         end
      end else begin
         gnt_q      <= wb.CYC_I;
         // Remember what the master last saw so DAT_O holds outside read ACKs.
         dat_hold_q <= dat_out;

         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rty_q     <= 1'b0;
         is_read_q <= 1'b0;
         if (accept) begin
            if (!cti_ok) begin
               rty_q <= 1'b1;
            end else if (!in_range) begin
               err_q <= 1'b1;
            end else begin
               ack_q <= 1'b1;
               if (wb.WE_I) begin
                  for (int k = 0; k < SEL_W; k++) begin
                     if (wb.SEL_I[k]) begin
                        mem[mem_idx][k*G +: G] <= wb.DAT_I[k*G +: G];
                     end
                  end
               end else begin
                  is_read_q <= 1'b1;
                  rd_data_q <= mem[mem_idx];
               end
            end
         end

         // Stall generator: one stall cycle after every STALL_EVERY accepts;
         // leaving the bus cycle restarts the count.
         if (!wb.CYC_I) begin
            beat_cnt <= '0;
            stall_q  <= 1'b0;
         end else begin
            stall_q <= 1'b0;
            if (accept && (STALL_EVERY != 0)) begin
               if (beat_cnt == CNT_W'(LAST_BEAT)) begin
                  beat_cnt <= '0;
                  stall_q  <= 1'b1;
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
         end
      end
   end

   // Terminations are qualified by CYC_I so a cycle dropped right after the
   // accepting edge never sees the response it abandoned.
   assign dat_out     = (ack_q && is_read_q && wb.CYC_I) ? rd_data_q : dat_hold_q;
   assign wb.DAT_O    = dat_out;
   assign wb.ACK_O    = ack_q & wb.CYC_I;
   assign wb.ERR_O    = err_q & wb.CYC_I;
   assign wb.RTY_O    = rty_q & wb.CYC_I;
   assign wb.STALL_O  = stall_q & wb.CYC_I;
   assign wb.gnt_wb_o = gnt_q;
endmodule

// File: tb/tb_wb_fake_slave_pipe_nb.sv
// -----------------------------------------------------------------------------
// tb_wb_fake_slave_pipe_nb
// Directed bench for wb_fake_slave_pipe_nb. A transaction-level model tracks
// the expected memory contents and the response owed for each accepted beat;
// a compare process checks every output on each falling edge. Directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_wb_fake_slave_pipe_nb;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int GR = 8;
   localparam int SW = DW / GR;
   localparam int MW = 16;
   localparam int SE = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wb_fake_slave_pipe_nb_if #(
      .BUS_ADDRESS_WIDTH(AW), .BUS_DATA_WIDTH(DW), .GRANULARITY(GR)
   ) bus ();

   wb_fake_slave_pipe_nb #(
      .BUS_ADDRESS_WIDTH(AW), .BUS_DATA_WIDTH(DW), .GRANULARITY(GR),
      .MEM_WORDS(MW), .STALL_EVERY(SE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wb (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_ack    = 0;
   int n_stall  = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum logic [2:0] {R_NONE, R_RD, R_WR, R_ERR, R_RTY} resp_e;

   resp_e         m_resp;
   logic [DW-1:0] m_data;
   logic [DW-1:0] m_dat_last;
   logic          m_gnt;
   logic          m_stall;
   int            m_beats;
   logic [DW-1:0] m_mem [MW];

   always @(posedge clk or negedge rst) begin
      logic           acc;
      longint unsigned idx;
      int             nb;
      resp_e          nr;
      if (!rst) begin
         m_resp     <= R_NONE;
         m_data     <= '0;
         m_dat_last <= '0;
         m_gnt      <= 1'b0;
         m_stall    <= 1'b0;
         m_beats    <= 0;
         for (int i = 0; i < MW; i++) m_mem[i] <= DW'(i);
      end else begin
         if (m_resp == R_RD && bus.CYC_I) m_dat_last <= m_data;
         acc = bus.CYC_I && bus.STB_I && !(m_stall && bus.CYC_I);
         nb  = bus.CYC_I ? m_beats : 0;
         m_gnt   <= bus.CYC_I;
         m_stall <= 1'b0;
         nr = R_NONE;
         if (acc) begin
            nb = nb + 1;
            if (SE != 0 && nb == SE) begin
               m_stall <= 1'b1;
               nb = 0;
            end
            idx = longint'(bus.ADR_I) / (DW / 8);
            if (!(bus.CTI_I == 3'b000 || bus.CTI_I == 3'b111)) nr = R_RTY;
            else if (idx >= MW) nr = R_ERR;
            else if (bus.WE_I) begin
               nr = R_WR;
               for (int k = 0; k < SW; k++)
                  if (bus.SEL_I[k]) m_mem[idx][k*GR +: GR] <= bus.DAT_I[k*GR +: GR];
            end else begin
               nr = R_RD;
               m_data <= m_mem[idx];
            end
         end
         m_beats <= nb;
         m_resp  <= nr;
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic          e_ack, e_err, e_rty, e_stall;
      logic [DW-1:0] e_dat;
      e_ack   = (m_resp == R_RD || m_resp == R_WR) && bus.CYC_I;
      e_err   = (m_resp == R_ERR) && bus.CYC_I;
      e_rty   = (m_resp == R_RTY) && bus.CYC_I;
      e_stall = m_stall && bus.CYC_I;
      e_dat   = (m_resp == R_RD && bus.CYC_I) ? m_data : m_dat_last;
      chk("ACK_O",    DW'(bus.ACK_O),    DW'(e_ack));
      chk("ERR_O",    DW'(bus.ERR_O),    DW'(e_err));
      chk("RTY_O",    DW'(bus.RTY_O),    DW'(e_rty));
      chk("STALL_O",  DW'(bus.STALL_O),  DW'(e_stall));
      chk("gnt_wb_o", DW'(bus.gnt_wb_o), DW'(m_gnt));
      chk("DAT_O",    bus.DAT_O,         e_dat);
      if (bus.ACK_O === 1'b1)   n_ack++;
      if (bus.STALL_O === 1'b1) n_stall++;
   end

   // ---------------- driver tasks ----------------
   task automatic bus_init();
      bus.CYC_I = 1'b0;
      bus.STB_I = 1'b0;
      bus.WE_I  = 1'b0;
      bus.ADR_I = '0;
      bus.DAT_I = '0;
      bus.SEL_I = '0;
      bus.CTI_I = 3'b000;
   endtask

   // Called just after a rising edge; returns just after the edge that
   // accepted the beat (request left asserted for back-to-back use).
   task automatic beat(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel, input logic [2:0] cti);
      int   waited = 0;
      logic done   = 1'b0;
      #1;
      bus.STB_I = 1'b1;
      bus.WE_I  = we;
      bus.ADR_I = adr;
      bus.DAT_I = dat;
      bus.SEL_I = sel;
      bus.CTI_I = cti;
      while (!done) begin
         @(negedge clk);
         if (bus.STALL_O !== 1'b1) done = 1'b1;
         @(posedge clk);
         if (!done) begin
            waited++;
            if (waited > 16) begin
               n_checks++;
               n_errors++;
               $display("FAIL stall_timeout: beat to 0x%0h still stalled after %0d cycles", adr, waited);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic open_cycle();
      #1 bus.CYC_I = 1'b1;
      @(posedge clk);
   endtask

   task automatic end_cycle();
      @(posedge clk);
      #1 bus.CYC_I = 1'b0;
      bus.STB_I = 1'b0;
      @(posedge clk);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int a0, s0;
      bus_init();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("reset_ack",   DW'(bus.ACK_O),    '0);
      chk("reset_stall", DW'(bus.STALL_O),  '0);
      chk("reset_gnt",   DW'(bus.gnt_wb_o), '0);
      chk("reset_dat",   bus.DAT_O,         '0);

      // Sustained read of address 0 with a mid-stream stall.
      @(posedge clk);
      #1 bus.CYC_I = 1'b1;
      repeat (3) @(posedge clk);
      a0 = n_ack;
      s0 = n_stall;
      #1;
      bus.STB_I = 1'b1;
      bus.WE_I  = 1'b0;
      bus.ADR_I = '0;
      bus.SEL_I = 4'hF;
      bus.CTI_I = 3'b000;
      repeat (6) @(posedge clk);
      #1 bus.STB_I = 1'b0;
      repeat (4) @(posedge clk);
      #1 bus.CYC_I = 1'b0;
      @(negedge clk);
      chk("t1_gnt_after_drop", DW'(bus.gnt_wb_o), 32'd1);
      chk("t1_no_ack_after",   DW'(bus.ACK_O),    32'd0);
      @(negedge clk);
      chk("t1_gnt_low",   DW'(bus.gnt_wb_o), 32'd0);
      chk("t1_ack_count", DW'(n_ack - a0),   32'd5);
      chk("t1_stall_cnt", DW'(n_stall - s0), 32'd1);

      // Partial-lane write then read back.
      end_cycle();
      open_cycle();
      beat(1'b1, 32'h8, 32'hDEADBEEF, 4'b0011, 3'b000);
      beat(1'b0, 32'h8, 32'h0,        4'hF,    3'b000);
      #1 bus.STB_I = 1'b0;
      @(negedge clk);
      chk("t2_ack", DW'(bus.ACK_O), 32'd1);
      chk("t2_dat", bus.DAT_O,      32'h0000BEEF);

      // Out-of-range read.
      end_cycle();
      open_cycle();
      beat(1'b0, 32'h40, 32'h0, 4'hF, 3'b000);
      #1 bus.STB_I = 1'b0;
      @(negedge clk);
      chk("t3_err", DW'(bus.ERR_O), 32'd1);
      chk("t3_ack", DW'(bus.ACK_O), 32'd0);

      // Burst cycle type -> retry; end-of-burst type is serviced.
      end_cycle();
      open_cycle();
      beat(1'b0, 32'h4, 32'h0, 4'hF, 3'b010);
      #1 bus.STB_I = 1'b0;
      @(negedge clk);
      chk("t4_rty", DW'(bus.RTY_O), 32'd1);
      chk("t4_ack", DW'(bus.ACK_O), 32'd0);
      @(posedge clk);
      beat(1'b0, 32'h4, 32'h0, 4'hF, 3'b111);
      #1 bus.STB_I = 1'b0;
      @(negedge clk);
      chk("t4_eob_ack", DW'(bus.ACK_O), 32'd1);
      chk("t4_eob_dat", bus.DAT_O,      32'd1);

      // Abort right after acceptance.
      end_cycle();
      open_cycle();
      beat(1'b0, 32'hC, 32'h0, 4'hF, 3'b000);
      #1;
      bus.CYC_I = 1'b0;
      bus.STB_I = 1'b0;
      @(negedge clk);
      chk("t5_no_ack",  DW'(bus.ACK_O),    32'd0);
      chk("t5_gnt_hi",  DW'(bus.gnt_wb_o), 32'd1);
      @(negedge clk);
      chk("t5_gnt_low", DW'(bus.gnt_wb_o), 32'd0);

      // Reset during a pending read; memory must reload.
      @(posedge clk);
      open_cycle();
      beat(1'b1, 32'h14, 32'hAAAAAAAA, 4'hF, 3'b000);
      beat(1'b0, 32'h14, 32'h0,        4'hF, 3'b000);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_ack",   DW'(bus.ACK_O),    '0);
      chk("t6_rst_dat",   bus.DAT_O,         '0);
      chk("t6_rst_gnt",   DW'(bus.gnt_wb_o), '0);
      chk("t6_rst_stall", DW'(bus.STALL_O),  '0);
      bus.CYC_I = 1'b0;
      bus.STB_I = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      open_cycle();
      beat(1'b0, 32'h14, 32'h0, 4'hF, 3'b000);
      #1 bus.STB_I = 1'b0;
      @(negedge clk);
      chk("t6_ack", DW'(bus.ACK_O), 32'd1);
      chk("t6_dat", bus.DAT_O,      32'd5);

      // Back-to-back writes and reads crossing several stall points.
      end_cycle();
      open_cycle();
      for (int i = 0; i < 8; i++)
         beat(1'b1, AW'((i + 6) * 4), 32'hA5A50000 + DW'(i * 257), SW'(i + 1), 3'b000);
      for (int i = 0; i < 8; i++)
         beat(1'b0, AW'((i + 6) * 4), 32'h0, 4'hF, 3'b000);
      beat(1'b0, 32'h3F, 32'h0, 4'hF, 3'b000);
      #1 bus.STB_I = 1'b0;
      @(negedge clk);
      chk("t7_ack_idx15", DW'(bus.ACK_O), 32'd1);
      chk("t7_dat_idx15", bus.DAT_O,      32'd15);
      end_cycle();
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
